// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg
// Shared constants and types for the register-file write-back arbiter slice.
//   REG_ADDR_W / DATA_W / NUM_REGS / ZERO_REG describe the 32x32 register file.
//   wb_req_t bundles one write (destination register plus data).
//   next_idx() gives the round-robin successor of a requester index.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_req_t;

    function automatic int next_idx(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
// Write-back request bus between the execute/memory requesters and the arbiter.
//   req_valid[i]  requester i holds a write
//   req_ready[i]  requester i accepted this cycle
//   req_addr      destination register, slice i = [5i+4:5i]
//   req_data      write data, slice i = [32i+31:32i]
// Modports: master (requester side), slave (arbiter side).
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [REG_ADDR_W*NUM_REQ-1:0] req_addr;
    logic [DATA_W*NUM_REQ-1:0]     req_data;

    modport master (
        output req_valid,
        output req_addr,
        output req_data,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_data,
        output req_ready
    );
endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter: searches req starting at index ptr and
// wrapping, grants the first active requester.
//   req        request vector
//   ptr        highest-priority index this cycle
//   grant      one-hot grant (zero when nothing requests)
//   grant_idx  encoded index of the granted requester
//   grant_vld  some requester was granted
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_vld && req[IDX_W'(idx)]) begin
                grant[IDX_W'(idx)] = 1'b1;
                grant_idx          = IDX_W'(idx);
                grant_vld          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port among NUM_REQ write-back
// requesters (round-robin, one registered output stage) and keeps a
// per-register pending-write scoreboard for decode-stage read stalls.
//   clock, reset              rising-edge clock, synchronous active-high reset
//   bus (slave)               write-back request bus (valid/ready/addr/data)
//   issue_valid/addr/ready    decode issue of an instruction writing issue_addr
//   flush                     clears every pending-write counter
//   rd_en_x/rd_addr_x         decode read ports; rd_stall_x when operand pending
//   wr_en/wr_addr/wr_data     register-file write port (one cycle after accept)
// Optional macro WB_BYPASS_EN adds byp_hit_a/byp_hit_b/byp_data: the read is
// released in the very cycle its last outstanding write reaches the file.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    regfile_wb_arbiter_if.slave   bus,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_addr,
    output logic                  issue_ready,
    input  logic                  flush,
    input  logic                  rd_en_a,
    input  logic                  rd_en_b,
    input  logic [REG_ADDR_W-1:0] rd_addr_a,
    input  logic [REG_ADDR_W-1:0] rd_addr_b,
    output logic                  rd_stall_a,
    output logic                  rd_stall_b,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     wr_data
`ifdef WB_BYPASS_EN
    ,
    output logic                  byp_hit_a,
    output logic                  byp_hit_b,
    output logic [DATA_W-1:0]     byp_data
`endif
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_vld;
    logic               xfer;
    wb_req_t            acc;
    logic               acc_writes;
    logic               issue_fire;
    logic [CNT_W-1:0]   cnt [NUM_REGS];
    logic               pend_a;
    logic               pend_b;
    logic               hit_a;
    logic               hit_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_arbiter (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    // No requester is accepted while reset is held, so a pending write is dropped.
    assign bus.req_ready = reset ? '0 : grant;
    assign xfer          = grant_vld & ~reset;

    always_comb begin
        acc = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                acc.addr = bus.req_addr[i*REG_ADDR_W +: REG_ADDR_W];
                acc.data = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // A write to x0 is accepted (and rotates priority) but never reaches the file.
    assign acc_writes = xfer && (acc.addr != ZERO_REG);

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (xfer) begin
            rr_ptr <= IDX_W'(next_idx(int'(grant_idx), NUM_REQ));
        end
    end

    // Output stage: write presented to the register file one cycle after accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_en   <= 1'b0;
            wr_addr <= ZERO_REG;
            wr_data <= '0;
        end else begin
            wr_en <= acc_writes;
            if (acc_writes) begin
                wr_addr <= acc.addr;
                wr_data <= acc.data;
            end
        end
    end

    // Scoreboard: a full counter refuses further issues to that register.
    assign issue_ready = reset || (issue_addr == ZERO_REG) || (cnt[issue_addr] != '1);
    assign issue_fire  = issue_valid && issue_ready && (issue_addr != ZERO_REG);

    always_ff @(posedge clock) begin
        cnt[0] <= '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            if (reset || flush) begin
                cnt[r] <= '0;
            end else if (issue_fire && (issue_addr == REG_ADDR_W'(r))) begin
                // A retiring write to the same register cancels the increment.
                if (!(wr_en && (wr_addr == REG_ADDR_W'(r)))) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end
            end else if (wr_en && (wr_addr == REG_ADDR_W'(r)) && (cnt[r] != '0)) begin
                // Writes already in flight at a flush find the counter at zero.
                cnt[r] <= cnt[r] - 1'b1;
            end
        end
    end

    assign pend_a = ~reset && rd_en_a && (rd_addr_a != ZERO_REG) && (cnt[rd_addr_a] != '0);
    assign pend_b = ~reset && rd_en_b && (rd_addr_b != ZERO_REG) && (cnt[rd_addr_b] != '0);

`ifdef WB_BYPASS_EN
    // The last outstanding producer is being written right now: forward it.
    assign hit_a = pend_a && wr_en && (wr_addr == rd_addr_a) && (cnt[rd_addr_a] == CNT_W'(1));
    assign hit_b = pend_b && wr_en && (wr_addr == rd_addr_b) && (cnt[rd_addr_b] == CNT_W'(1));
    assign byp_hit_a = hit_a;
    assign byp_hit_b = hit_b;
    assign byp_data  = wr_data;
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
`endif

    assign rd_stall_a = pend_a && !hit_a;
    assign rd_stall_b = pend_b && !hit_b;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ = 3;

    logic        clock;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_addr;
    logic        issue_ready;
    logic        flush;
    logic        rd_en_a;
    logic        rd_en_b;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        rd_stall_a;
    logic        rd_stall_b;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
`ifdef WB_BYPASS_EN
    logic        byp_hit_a;
    logic        byp_hit_b;
    logic [31:0] byp_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] DA = 32'hA0A0_0005;
    localparam logic [31:0] DB = 32'hB0B0_0006;
    localparam logic [31:0] DC = 32'hC0C0_0007;
    localparam logic [31:0] DD = 32'hD0D0_000A;
    localparam logic [31:0] DE = 32'hE0E0_0009;
    localparam logic [31:0] DF = 32'hF0F0_0004;
    localparam logic [31:0] DG = 32'h1234_000C;
    localparam logic [31:0] DH = 32'h5678_000F;

    regfile_wb_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    regfile_wb_arbiter #(
        .NUM_REQ (NUM_REQ),
        .CNT_W   (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_ready (issue_ready),
        .flush       (flush),
        .rd_en_a     (rd_en_a),
        .rd_en_b     (rd_en_b),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_stall_a  (rd_stall_a),
        .rd_stall_b  (rd_stall_b),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
`ifdef WB_BYPASS_EN
        ,
        .byp_hit_a   (byp_hit_a),
        .byp_hit_b   (byp_hit_b),
        .byp_data    (byp_data)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        bus.req_addr[i*5 +: 5]  = a;
        bus.req_data[i*32 +: 32] = d;
    endtask

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        issue_valid   = 1'b0;
        issue_addr    = 5'd0;
        rd_en_a       = 1'b1;
        rd_addr_a     = 5'd5;
        rd_en_b       = 1'b0;
        rd_addr_b     = 5'd0;
        bus.req_valid = 3'b111;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        set_req(0, 5'd5, DA);
        set_req(1, 5'd6, DB);
        set_req(2, 5'd7, DC);

        // Reset state, with all requesters already valid
        step();
        step();
        #1;
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_data", wr_data, 32'd0);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_issue_ready", 32'(issue_ready), 32'd1);
        check("rst_stall_a", 32'(rd_stall_a), 32'd0);

        // Three requesters held valid: grants 0,1,2 in turn
        reset = 1'b0;
        #1;
        check("rr_ready0", 32'(bus.req_ready), 32'b001);
        step();
        check("rr_wr0_en", 32'(wr_en), 32'd1);
        check("rr_wr0_addr", 32'(wr_addr), 32'd5);
        check("rr_wr0_data", wr_data, DA);
        check("rr_ready1", 32'(bus.req_ready), 32'b010);
        step();
        check("rr_wr1_addr", 32'(wr_addr), 32'd6);
        check("rr_wr1_data", wr_data, DB);
        check("rr_ready2", 32'(bus.req_ready), 32'b100);
        step();
        check("rr_wr2_en", 32'(wr_en), 32'd1);
        check("rr_wr2_addr", 32'(wr_addr), 32'd7);
        check("rr_wr2_data", wr_data, DC);
        check("rr_ready_wrap", 32'(bus.req_ready), 32'b001);
        bus.req_valid = 3'b000;
        #1;
        check("idle_ready", 32'(bus.req_ready), 32'b000);
        step();
        check("idle_wr_en", 32'(wr_en), 32'd0);
        check("idle_hold_addr", 32'(wr_addr), 32'd7);
        check("idle_hold_data", wr_data, DC);

        // Only requester 1 valid for four cycles
        set_req(1, 5'd10, DD);
        bus.req_valid = 3'b010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("solo_ready", 32'(bus.req_ready), 32'b010);
            step();
            check("solo_wr_en", 32'(wr_en), 32'd1);
            check("solo_wr_addr", 32'(wr_addr), 32'd10);
        end
        bus.req_valid = 3'b111;
        #1;
        check("solo_ptr_is_2", 32'(bus.req_ready), 32'b100);
        bus.req_valid = 3'b000;
        step();
        check("solo_end_wr_en", 32'(wr_en), 32'd0);

        // Fill the counter for x9, fourth issue refused
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        rd_en_b     = 1'b1;
        rd_addr_b   = 5'd9;
        #1;
        check("fill_ready0", 32'(issue_ready), 32'd1);
        check("fill_stall_b0", 32'(rd_stall_b), 32'd0);
        step();
        check("fill_ready1", 32'(issue_ready), 32'd1);
        step();
        check("fill_ready2", 32'(issue_ready), 32'd1);
        check("fill_stall_b2", 32'(rd_stall_b), 32'd1);
        step();
        check("fill_full", 32'(issue_ready), 32'd0);
        step();
        check("fill_still_full", 32'(issue_ready), 32'd0);
        issue_valid = 1'b0;
        set_req(0, 5'd9, DE);
        bus.req_valid = 3'b001;
        #1;
        check("x9_ready", 32'(bus.req_ready), 32'b001);
        step();
        bus.req_valid = 3'b000;
        check("x9_wr_en", 32'(wr_en), 32'd1);
        check("x9_wr_addr", 32'(wr_addr), 32'd9);
        check("x9_wr_data", wr_data, DE);
        check("x9_full_during_wr", 32'(issue_ready), 32'd0);
        step();
        check("x9_after_wr_ready", 32'(issue_ready), 32'd1);
        check("x9_after_wr_stall", 32'(rd_stall_b), 32'd1);

        // Read stall on x4 until its write reaches the file
        issue_valid = 1'b1;
        issue_addr  = 5'd4;
        rd_en_a     = 1'b1;
        rd_addr_a   = 5'd4;
        #1;
        check("x4_stall_before", 32'(rd_stall_a), 32'd0);
        step();
        issue_valid = 1'b0;
        check("x4_stall_pending", 32'(rd_stall_a), 32'd1);
        set_req(2, 5'd4, DF);
        bus.req_valid = 3'b100;
        #1;
        check("x4_ready", 32'(bus.req_ready), 32'b100);
        check("x4_stall_at_accept", 32'(rd_stall_a), 32'd1);
        step();
        bus.req_valid = 3'b000;
        check("x4_wr_en", 32'(wr_en), 32'd1);
        check("x4_wr_addr", 32'(wr_addr), 32'd4);
`ifdef WB_BYPASS_EN
        check("x4_byp_stall", 32'(rd_stall_a), 32'd0);
        check("x4_byp_hit", 32'(byp_hit_a), 32'd1);
        check("x4_byp_data", byp_data, DF);
`else
        check("x4_wr_cycle_stall", 32'(rd_stall_a), 32'd1);
`endif
        step();
        check("x4_stall_cleared", 32'(rd_stall_a), 32'd0);
        check("x4_wr_en_off", 32'(wr_en), 32'd0);

        // Same-cycle issue and write of x3 with cnt[3]=1
        issue_valid = 1'b1;
        issue_addr  = 5'd3;
        step();
        issue_valid = 1'b0;
        set_req(0, 5'd3, 32'h0000_0333);
        bus.req_valid = 3'b001;
        step();
        bus.req_valid = 3'b000;
        check("x3_wr_en", 32'(wr_en), 32'd1);
        check("x3_wr_addr", 32'(wr_addr), 32'd3);
        issue_valid = 1'b1;
        issue_addr  = 5'd3;
        #1;
        check("x3_issue_ready", 32'(issue_ready), 32'd1);
        step();
        issue_valid = 1'b0;
        rd_addr_b   = 5'd3;
        #1;
        check("x3_cnt_kept_a", 32'(rd_stall_b), 32'd1);
        step();
        check("x3_cnt_kept_b", 32'(rd_stall_b), 32'd1);
        bus.req_valid = 3'b001;
        step();
        bus.req_valid = 3'b000;
        step();
        check("x3_cnt_was_one", 32'(rd_stall_b), 32'd0);

        // Transfer to x0: accepted, rotates, no write
        set_req(1, 5'd0, 32'hDEAD_0000);
        bus.req_valid = 3'b010;
        #1;
        check("x0_ready", 32'(bus.req_ready), 32'b010);
        step();
        bus.req_valid = 3'b000;
        check("x0_no_wr_en", 32'(wr_en), 32'd0);
        check("x0_hold_addr", 32'(wr_addr), 32'd3);
        bus.req_valid = 3'b111;
        #1;
        check("x0_rotated", 32'(bus.req_ready), 32'b100);
        bus.req_valid = 3'b000;
        step();
        check("x0_idle_wr_en", 32'(wr_en), 32'd0);

        // Flush with cnt[12]=2 and a write to x12 accepted in the flush cycle
        issue_valid = 1'b1;
        issue_addr  = 5'd12;
        step();
        step();
        set_req(0, 5'd12, DG);
        bus.req_valid = 3'b001;
        flush         = 1'b1;
        rd_addr_a     = 5'd12;
        rd_addr_b     = 5'd9;
        #1;
        check("fl_ready", 32'(bus.req_ready), 32'b001);
        check("fl_stall_a_pre", 32'(rd_stall_a), 32'd1);
        check("fl_stall_b_pre", 32'(rd_stall_b), 32'd1);
        check("fl_issue_ready_pre", 32'(issue_ready), 32'd1);
        step();
        flush         = 1'b0;
        issue_valid   = 1'b0;
        bus.req_valid = 3'b000;
        check("fl_wr_en", 32'(wr_en), 32'd1);
        check("fl_wr_addr", 32'(wr_addr), 32'd12);
        check("fl_wr_data", wr_data, DG);
        check("fl_stall_a_post", 32'(rd_stall_a), 32'd0);
        check("fl_stall_b_post", 32'(rd_stall_b), 32'd0);
        step();
        check("fl_cnt12_stays0", 32'(rd_stall_a), 32'd0);
        check("fl_wr_en_off", 32'(wr_en), 32'd0);

        // Reset asserted with a transfer pending
        set_req(1, 5'd15, DH);
        bus.req_valid = 3'b010;
        reset         = 1'b1;
        #1;
        check("rst2_ready", 32'(bus.req_ready), 32'b000);
        check("rst2_issue_ready", 32'(issue_ready), 32'd1);
        step();
        check("rst2_wr_en", 32'(wr_en), 32'd0);
        check("rst2_wr_addr", 32'(wr_addr), 32'd0);
        check("rst2_wr_data", wr_data, 32'd0);
        reset         = 1'b0;
        bus.req_valid = 3'b111;
        #1;
        check("rst2_ptr_zero", 32'(bus.req_ready), 32'b001);
        bus.req_valid = 3'b000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the register file's single write port among NUM_REQ write-back requesters (ALU, load unit, mul/div) using round-robin arbitration with a one-cycle registered output stage. Keeps a per-register pending-write scoreboard so the decode stage can stall its read ports on outstanding producers. Sits between the execute/memory write-back sources and the 32x32 register file.

Parameters:
NUM_REQ, 3, number of write-back requesters (2..4)
CNT_W, 2, width of each per-register pending-write counter

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high
req_valid  input  NUM_REQ  requester i holds a write
req_ready  output  NUM_REQ  requester i accepted this cycle
req_addr  input  5*NUM_REQ  destination register, slice i = [5i+4:5i]
req_data  input  32*NUM_REQ  write data, slice i = [32i+31:32i]
issue_valid  input  1  decode issues an instruction that will write issue_addr
issue_addr  input  5  destination of issued instruction
issue_ready  output  1  scoreboard can track this issue
flush  input  1  pipeline flush; clears scoreboard
rd_en_a / rd_en_b  input  1 each  decode read-port enables
rd_addr_a / rd_addr_b  input  5 each  decode read addresses
rd_stall_a / rd_stall_b  output  1 each  operand not yet available
wr_en  output  1  register-file write enable
wr_addr  output  5  register-file write address
wr_data  output  32  register-file write data

Behaviour:
- Reset: wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0, all counters=0. req_ready=0 during reset; issue_ready=1; stalls=0.
- Arbitration: combinational round-robin over req_valid, starting at rr_ptr. At most one req_ready bit high, and only for a valid requester. Transfer = valid & ready.
- On transfer from requester g: rr_ptr <= (g+1) mod NUM_REQ. No transfer: rr_ptr holds.
- Output stage: latency 1. Cycle after a transfer, wr_en=1 and wr_addr/wr_data = accepted values. Otherwise wr_en=0, with addr/data holding their last values.
- A transfer with req_addr=0 is accepted and rotates rr_ptr, but produces wr_en=0 and no counter change.
- Scoreboard: cnt[r] for r=1..31; cnt[0] is constant 0.
  - Increment on issue_valid & issue_ready & issue_addr!=0.
  - Decrement on registered wr_en for wr_addr; saturates at 0.
  - Increment and decrement on the same register in the same cycle: counter unchanged.
- issue_ready = (issue_addr==0) | (cnt[issue_addr] != 2^CNT_W-1), i.e. counter full blocks issue.
- Flush: all counters <= 0 next edge; any issue in the same cycle is ignored. Arbiter and output stage are unaffected, so in-flight writes still complete (their decrements saturate).
- rd_stall_x = rd_en_x & rd_addr_x!=0 & cnt[rd_addr_x]!=0, modified by the optional bypass below.
- Reset mid-operation: an accepted-but-unwritten write is dropped (wr_en=0 next cycle).

Optional Feature:
WB_BYPASS_EN.
- Defined: adds outputs byp_hit_a/byp_hit_b (1) and byp_data (32). When wr_en & wr_addr==rd_addr_x & cnt[rd_addr_x]==1, then byp_hit_x=1, rd_stall_x=0, and byp_data=wr_data. This covers the register file's same-cycle negedge write.
- Undefined: these ports are absent, and rd_stall_x follows the base rule (stall whenever cnt!=0).

Decomposition:
- Shared package holds: REG_ADDR_W=5, DATA_W=32, NUM_REGS=32, ZERO_REG=0.
- One sub-module, rr_arbiter (NUM_REQ parameter; req, ptr -> one-hot grant plus encoded index), reusable by other shared-resource arbiters.
- Scoreboard counters stay inline.

Test Plan:
- Reset, then all three requesters valid (addr 5/6/7, data A/B/C) held -> grants 0,1,2 on consecutive cycles; wr_en pulses with (5,A),(6,B),(7,C) one cycle after each grant.
- Only req1 valid for 4 cycles -> req_ready=0010 every cycle, rr_ptr=2 after each, four writes to req1's addr.
- Issue addr 9 three times, then a fourth -> cnt[9]=3 and issue_ready=0 on the fourth. Then a write to 9 -> cnt=2 and issue_ready=1.
- Issue addr 4, rd_en_a with rd_addr_a=4 -> rd_stall_a=1 until the wr_en cycle for addr 4. That cycle: stall=0 with byp_hit_a=1 and byp_data=data if WB_BYPASS_EN, otherwise the stall clears the cycle after.
- Same-cycle issue of addr 3 and write of addr 3 with cnt[3]=1 -> cnt[3] stays 1. req_addr=0 transfer -> no wr_en, rotation advances.
- Flush with cnt[12]=2 and one in-flight write to 12 -> all counters 0 next cycle, the write still occurs, cnt[12] stays 0. Assert reset with a transfer pending -> wr_en=0 next cycle.
